// File: rtl/cond_pkg.sv
// cond_pkg: shared condition codes and NZCV flag layout for the condition unit and its reusers.
//   cond_e          ARM condition-field encodings (EQ..NV)
//   FLAG_N..FLAG_V  bit positions inside a 4-bit NZCV vector
//   FLAG_W          width of an NZCV vector
package cond_pkg;

    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition check of a 4-bit condition field against NZCV.
//   cond_i  in  4       condition field
//   nzcv_i  in  FLAG_W  flags to test
//   pass_o  out 1       condition passes
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0]        cond_i,
    input  logic [FLAG_W-1:0] nzcv_i,
    output logic              pass_o
);

    logic n, z, c, v;

    assign n = nzcv_i[FLAG_N];
    assign z = nzcv_i[FLAG_Z];
    assign c = nzcv_i[FLAG_C];
    assign v = nzcv_i[FLAG_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c & !z;
            COND_LS: pass_o = !c | z;
            COND_GE: pass_o = n == v;
            COND_LT: pass_o = n != v;
            COND_GT: pass_o = !z & (n == v);
            COND_LE: pass_o = z | (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_pipe.sv
// cond_unit_pipe: E->M conditional-execution unit with NZCV register, save slot and E->M control registers.
//   CLK, RESET                  clock, synchronous active-high reset
//   StallE, FlushE              hold / squash the E->M registers
//   CondE, CtrlE, FlagWE        condition, raw control bits, flag write enables of the E instruction
//   ALUFlagsM                   NZCV result of the instruction in M
//   SaveFlagsE, RestoreFlagsE   save-slot capture / flags restore
//   CondExE, CtrlM              condition result, registered gated control
//   FlagsQ, SavedFlags          architectural flags, save slot
//   FlagHazardE                 E reads flags still pending in M
// Build option: define COND_FLAG_FWD_EN to forward the pending M flag write into E
// instead of raising FlagHazardE.
module cond_unit_pipe
    import cond_pkg::*;
#(
    parameter int                CTRL_W      = 3,
    parameter logic [FLAG_W-1:0] RESET_FLAGS = 4'b0000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic [3:0]        CondE,
    input  logic [CTRL_W-1:0] CtrlE,
    input  logic [1:0]        FlagWE,
    input  logic [FLAG_W-1:0] ALUFlagsM,
    input  logic              SaveFlagsE,
    input  logic              RestoreFlagsE,
    output logic              CondExE,
    output logic [CTRL_W-1:0] CtrlM,
    output logic [FLAG_W-1:0] FlagsQ,
    output logic [FLAG_W-1:0] SavedFlags,
    output logic              FlagHazardE
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [1:0]        flagw_q, flagw_d;
    logic              pend_q, pend_d;
    logic [FLAG_W-1:0] flags_q, flags_d, saved_q, eff_flags;

`ifdef COND_FLAG_FWD_EN
    assign eff_flags = {flagw_q[1] ? ALUFlagsM[FLAG_N:FLAG_Z] : flags_q[FLAG_N:FLAG_Z],
                        flagw_q[0] ? ALUFlagsM[FLAG_C:FLAG_V] : flags_q[FLAG_C:FLAG_V]};
    assign FlagHazardE = 1'b0;
`else
    assign eff_flags = flags_q;
    // AL and NV do not read the flags, so they never need to wait.
    assign FlagHazardE = pend_q & (CondE != COND_AL) & (CondE != COND_NV);
`endif

    cond_eval u_eval (
        .cond_i (CondE),
        .nzcv_i (eff_flags),
        .pass_o (CondExE)
    );

    assign ctrl_d  = FlushE ? '0 : CtrlE & {CTRL_W{CondExE}};
    assign flagw_d = FlushE ? '0 : FlagWE & {2{CondExE}};
    assign pend_d  = |flagw_d;

    // The M write is independent of StallE: the instruction in M has already committed.
    always_comb begin
        flags_d = flags_q;
        if (RestoreFlagsE && !StallE) begin
            flags_d = saved_q;
        end else begin
            if (flagw_q[1]) flags_d[FLAG_N:FLAG_Z] = ALUFlagsM[FLAG_N:FLAG_Z];
            if (flagw_q[0]) flags_d[FLAG_C:FLAG_V] = ALUFlagsM[FLAG_C:FLAG_V];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_q  <= '0;
            flagw_q <= '0;
            pend_q  <= 1'b0;
            flags_q <= RESET_FLAGS;
            saved_q <= RESET_FLAGS;
        end else begin
            if (!StallE) begin
                ctrl_q  <= ctrl_d;
                flagw_q <= flagw_d;
                pend_q  <= pend_d;
                if (SaveFlagsE) saved_q <= eff_flags;
            end
            flags_q <= flags_d;
        end
    end

    assign CtrlM      = ctrl_q;
    assign FlagsQ     = flags_q;
    assign SavedFlags = saved_q;

endmodule

// File: tb/tb_cond_unit_pipe.sv
// tb_cond_unit_pipe: directed, table-driven self-checking bench for cond_unit_pipe.
module tb_cond_unit_pipe;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] nzcv;
        logic       exp;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET, StallE, FlushE, SaveFlagsE, RestoreFlagsE;
    logic [3:0] CondE, ALUFlagsM;
    logic [2:0] CtrlE;
    logic [1:0] FlagWE;
    logic       CondExE, FlagHazardE;
    logic [2:0] CtrlM;
    logic [3:0] FlagsQ, SavedFlags;

    int checks = 0;
    int errors = 0;
    vec_t tbl[256];

    cond_unit_pipe dut (
        .CLK(CLK), .RESET(RESET), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .CtrlE(CtrlE), .FlagWE(FlagWE), .ALUFlagsM(ALUFlagsM),
        .SaveFlagsE(SaveFlagsE), .RestoreFlagsE(RestoreFlagsE),
        .CondExE(CondExE), .CtrlM(CtrlM), .FlagsQ(FlagsQ),
        .SavedFlags(SavedFlags), .FlagHazardE(FlagHazardE)
    );

    always #5 CLK = ~CLK;

    // Reference decode built from the ARM pairing: even code tests a base condition,
    // odd code inverts it.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = n == v;
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Loads NZCV through the M write path, leaving FlagWM cleared.
    task automatic set_flags(input logic [3:0] v);
        CondE = 4'b1110; FlagWE = 2'b11; CtrlE = 3'b000;
        tick;
        ALUFlagsM = v; FlagWE = 2'b00;
        tick;
    endtask

    initial begin
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 16; c++)
                tbl[f*16+c] = '{cond: 4'(c), nzcv: 4'(f), exp: ref_cond(4'(c), 4'(f))};

        RESET = 1'b1; StallE = 1'b0; FlushE = 1'b0; SaveFlagsE = 1'b0; RestoreFlagsE = 1'b0;
        CondE = 4'b0000; CtrlE = 3'b111; FlagWE = 2'b00; ALUFlagsM = 4'b0000;
        tick; tick;
        RESET = 1'b0;
        chk("reset_flags", 8'(FlagsQ), 8'h0);
        chk("reset_saved", 8'(SavedFlags), 8'h0);
        chk("reset_ctrlm", 8'(CtrlM), 8'h0);
        chk("reset_hazard", 8'(FlagHazardE), 8'h0);

        chk("eq_after_reset", 8'(CondExE), 8'h0);
        tick;
        chk("eq_gated_ctrlm", 8'(CtrlM), 8'h0);

        // CMP producing Z=1 followed by EQ in E
        CondE = 4'b1110; FlagWE = 2'b10; CtrlE = 3'b000;
        tick;
        ALUFlagsM = 4'b0100; CondE = 4'b0000; CtrlE = 3'b101; FlagWE = 2'b00;
        #1;
`ifdef COND_FLAG_FWD_EN
        chk("fwd_condex", 8'(CondExE), 8'h1);
        chk("fwd_hazard", 8'(FlagHazardE), 8'h0);
        tick;
        chk("fwd_flags", 8'(FlagsQ), 8'h4);
`else
        chk("haz_hazard", 8'(FlagHazardE), 8'h1);
        chk("haz_condex_stale", 8'(CondExE), 8'h0);
        StallE = 1'b1;
        tick;
        StallE = 1'b0;
        chk("haz_flags", 8'(FlagsQ), 8'h4);
        chk("haz_condex", 8'(CondExE), 8'h1);
        tick;
`endif
        chk("cmp_eq_ctrlm", 8'(CtrlM), 8'h5);

        // Failing NE with Z=1 must not schedule a flag write
        CondE = 4'b0001; FlagWE = 2'b11; CtrlE = 3'b111; ALUFlagsM = 4'b1011;
        #1;
        chk("ne_fail", 8'(CondExE), 8'h0);
        tick;
        chk("ne_ctrlm", 8'(CtrlM), 8'h0);
        chk("ne_no_pend", 8'(FlagHazardE), 8'h0);
        CondE = 4'b1110; FlagWE = 2'b00;
        tick;
        chk("ne_flags_kept", 8'(FlagsQ), 8'h4);

        // Save / overwrite / restore
        set_flags(4'b1001);
        chk("sr_flags_init", 8'(FlagsQ), 8'h9);
        SaveFlagsE = 1'b1;
        tick;
        SaveFlagsE = 1'b0;
        chk("sr_saved", 8'(SavedFlags), 8'h9);
        set_flags(4'b0110);
        chk("sr_flags_over", 8'(FlagsQ), 8'h6);
        chk("sr_saved_kept", 8'(SavedFlags), 8'h9);
        RestoreFlagsE = 1'b1; StallE = 1'b1;
        tick;
        chk("sr_restore_stalled", 8'(FlagsQ), 8'h6);
        StallE = 1'b0;
        tick;
        RestoreFlagsE = 1'b0;
        chk("sr_restored", 8'(FlagsQ), 8'h9);
        chk("sr_saved_end", 8'(SavedFlags), 8'h9);
        set_flags(4'b0011);
        SaveFlagsE = 1'b1; RestoreFlagsE = 1'b1;
        tick;
        SaveFlagsE = 1'b0; RestoreFlagsE = 1'b0;
        chk("sr_both_flags", 8'(FlagsQ), 8'h9);
        chk("sr_both_saved", 8'(SavedFlags), 8'h3);

        // Stall hold, then flush
        CondE = 4'b1110; CtrlE = 3'b011;
        tick;
        chk("stall_pre", 8'(CtrlM), 8'h3);
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            CtrlE = i[0] ? 3'b011 : 3'b100;
            tick;
            chk("stall_hold", 8'(CtrlM), 8'h3);
        end
        StallE = 1'b0; FlushE = 1'b1; CtrlE = 3'b111; FlagWE = 2'b11;
        tick;
        FlushE = 1'b0; FlagWE = 2'b00; CondE = 4'b0000;
        #1;
        chk("flush_ctrlm", 8'(CtrlM), 8'h0);
        chk("flush_no_pend", 8'(FlagHazardE), 8'h0);

        // Reset discards a pending M write
        CondE = 4'b1110; FlagWE = 2'b11;
        tick;
        ALUFlagsM = 4'b1111; RESET = 1'b1; FlagWE = 2'b00;
        tick;
        RESET = 1'b0;
        chk("rst_mid_flags", 8'(FlagsQ), 8'h0);
        chk("rst_mid_saved", 8'(SavedFlags), 8'h0);
        tick;
        chk("rst_mid_after", 8'(FlagsQ), 8'h0);

        // Full decode sweep
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            chk("sweep_flags", 8'(FlagsQ), 8'(f));
            for (int c = 0; c < 16; c++) begin
                CondE = tbl[f*16+c].cond;
                #1;
                chk($sformatf("sweep_c%0h_f%0h", tbl[f*16+c].cond, tbl[f*16+c].nzcv),
                    8'(CondExE), 8'(tbl[f*16+c].exp));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
